serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 8 +
 rtl/Adder.sv | 11 +
 rtl/serial_adder_ctrl.sv | 75 +++++++
 tb/tb_serial_adder_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encodings for the serial adder sequencer
package serial_adder_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/Adder.sv
// Adder: combinational 1-bit full adder cell (led_0 = sum, led_1 = carry)
module Adder (
  input  logic switch_0,
  input  logic switch_1,
  input  logic switch_2,
  output logic led_0,
  output logic led_1
);
  assign led_0 = switch_0 ^ switch_1 ^ switch_2;
  assign led_1 = (switch_0 & switch_1) | (switch_2 & (switch_0 ^ switch_1));
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: WIDTH-bit add by reusing one full adder over WIDTH cycles, LSB first
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a_sh, r_b_sh, r_sum_sh, r_sum, w_sum_nx;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry, r_cout, w_s, w_c, w_last;
  Adder u_adder (
    .switch_0(r_a_sh[0]),
    .switch_1(r_b_sh[0]),
    .switch_2(r_carry),
    .led_0   (w_s),
    .led_1   (w_c)
  );
  assign w_last   = r_cnt == CNT_W'(WIDTH - 1);
  assign w_sum_nx = WIDTH'({w_s, r_sum_sh} >> 1);
  assign busy     = r_state == ST_RUN;
  assign done     = r_state == ST_DONE;
  assign sum      = r_sum;
  assign cout     = r_cout;
  // state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else r_state <= w_next;
  end
  // next state: start only honoured in IDLE, DONE lasts a single cycle
  always_comb begin
    w_next = ST_IDLE;
    w_next = (r_state == ST_IDLE) ? (start ? ST_RUN : ST_IDLE) :
             (r_state == ST_RUN)  ? (w_last ? ST_DONE : ST_RUN) : ST_IDLE;
  end
  // datapath: load operands on accepted start, then shift one bit pair per RUN cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_sum    <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_cnt    <= '0;
    end else if (r_state == ST_IDLE && start) begin
      r_a_sh   <= a;
      r_b_sh   <= b;
      r_sum_sh <= '0;
      r_carry  <= cin;
      r_cnt    <= '0;
    end else if (r_state == ST_RUN) begin
      r_a_sh   <= r_a_sh >> 1;
      r_b_sh   <= r_b_sh >> 1;
      r_sum_sh <= w_sum_nx;
      r_carry  <= w_c;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_sum  <= w_sum_nx;
        r_cout <= w_c;
      end
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: scoreboard bench for WIDTH=8 and WIDTH=1 instances
module tb_serial_adder_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic start8 = 1'b0, cin8 = 1'b0, busy8, done8, cout8;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic start1 = 1'b0, cin1 = 1'b0, busy1, done1, cout1;
  logic [0:0] a1 = '0, b1 = '0, sum1;
  logic [8:0] q8[$];
  logic [1:0] q1[$];
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );
  serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("done_while_busy8", {63'd0, done8 & busy8}, 64'd0);
      if (done8) begin
        if (q8.size() == 0) chk("spurious_done8", 64'd1, 64'd0);
        else chk("result8", {55'd0, cout8, sum8}, {55'd0, q8.pop_front()});
      end
      if (done1) begin
        if (q1.size() == 0) chk("spurious_done1", 64'd1, 64'd0);
        else chk("result1", {62'd0, cout1, sum1}, {62'd0, q1.pop_front()});
      end
    end
  end

  task automatic wait_idle8();
    int n = 0;
    while ((busy8 || done8) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) chk("idle8_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_done8(output int lat, output int bcnt);
    lat = 1;
    bcnt = 0;
    while (!done8 && lat < 40) begin
      bcnt += int'(busy8);
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input bit timing);
    int lat, bcnt;
    wait_idle8();
    a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
    q8.push_back({1'b0, ta} + {1'b0, tb} + 9'(tc));
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = ~ta; b8 = ~tb; cin8 = ~tc;
    wait_done8(lat, bcnt);
    if (timing || lat >= 40) begin
      chk("latency8", 64'(lat), 64'd9);
      chk("busy_cycles8", 64'(bcnt), 64'd8);
    end
    @(posedge clk); #1;
    if (timing) chk("done_clear8", {62'd0, done8, busy8}, 64'd0);
  endtask

  task automatic run1(input logic ta, input logic tb, input logic tc);
    int lat = 1;
    a1 = ta; b1 = tb; cin1 = tc; start1 = 1'b1;
    q1.push_back({1'b0, ta} + {1'b0, tb} + {1'b0, tc});
    @(posedge clk); #1;
    start1 = 1'b0;
    chk("busy1", {63'd0, busy1}, 64'd1);
    while (!done1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency1", 64'(lat), 64'd2);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, bcnt;
    repeat (3) @(posedge clk);
    #1;
    chk("reset8", {53'd0, busy8, done8, cout8, sum8}, 64'd0);
    chk("reset1", {60'd0, busy1, done1, cout1, sum1}, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    run8(8'h03, 8'h05, 1'b0, 1'b1);
    chk("hold_sum8", {55'd0, cout8, sum8}, 64'h008);
    run8(8'hFF, 8'h01, 1'b0, 1'b1);
    run8(8'hFF, 8'hFF, 1'b1, 1'b1);
    wait_idle8();
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    q8.push_back(9'h030);
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    start8 = 1'b1; a8 = 8'hAA;
    @(posedge clk); #1;
    start8 = 1'b0;
    wait_done8(lat, bcnt);
    chk("ignore_run_latency", 64'(lat), 64'd6);
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) begin
      chk("ignore_done_idle", {62'd0, busy8, done8}, 64'd0);
      @(posedge clk); #1;
    end
    wait_idle8();
    a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    q8.push_back(9'h080);
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    q8.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort8", {53'd0, busy8, done8, cout8, sum8}, 64'd0);
    run8(8'h02, 8'h02, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) run1(1'(i >> 2), 1'(i >> 1), 1'(i));
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      run8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
    end
    repeat (4) @(posedge clk);
    #1;
    chk("q8_drained", 64'(q8.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
